perceptron_trainer: RTL and testbench

Sequential training stage wrapped around the combinational perceptron neuron. Collects one sample vector X serially with its target label, drives the X and W buses into the neuron and samples its 1-bit decision S. On a misclassification it applies the perceptron rule W[i] += (target ? +X[i] : −X[i]), one weight per cycle. Owns the weight register bank; the neuron holds no state.

---
 rtl/perceptron_pkg.sv | 30 +++
 rtl/weight_updater.sv | 31 +++
 rtl/perceptron_trainer.sv | 140 ++++++++++++++
 tb/tb_perceptron_trainer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types, constants and the weight reduction helper for perceptron_trainer.
package perceptron_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StEval,
        StUpdate,
        StResult
    } state_e;

    localparam int unsigned ERR_CNT_W = 16;

    // Clamps to the signed nbits range when sat is set; otherwise the caller's truncation wraps.
    function automatic logic signed [31:0] fit_weight(input logic signed [31:0] sum,
                                                      input int unsigned nbits,
                                                      input logic sat);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (nbits - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (nbits - 1));
        if (sat && (sum > hi)) begin
            return hi;
        end
        if (sat && (sum < lo)) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/weight_updater.sv
// Combinational W +/- X at NUM_BITS+1, reduced back to NUM_BITS.
// Saturates when PERCEPTRON_TRAINER_SAT_EN is defined, wraps otherwise.
module weight_updater
    import perceptron_pkg::*;
#(
    parameter int unsigned NUM_BITS = 4
) (
    input  logic [NUM_BITS-1:0] w_i,
    input  logic [NUM_BITS-1:0] x_i,
    input  logic                add_i,
    output logic [NUM_BITS-1:0] w_o
);

`ifdef PERCEPTRON_TRAINER_SAT_EN
    localparam logic SatEn = 1'b1;
`else
    localparam logic SatEn = 1'b0;
`endif

    logic signed [NUM_BITS:0] w_ext;
    logic signed [NUM_BITS:0] x_ext;
    logic signed [NUM_BITS:0] sum;

    always_comb begin
        w_ext = {w_i[NUM_BITS-1], w_i};
        x_ext = {x_i[NUM_BITS-1], x_i};
        sum   = add_i ? (w_ext + x_ext) : (w_ext - x_ext);
        w_o   = NUM_BITS'(fit_weight(32'(sum), NUM_BITS, SatEn));
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron training stage: loads X serially, samples the external neuron, updates W on a miss.
// Weight overflow handling is selected by PERCEPTRON_TRAINER_SAT_EN (see weight_updater).
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 18,
    parameter int unsigned NUM_BITS    = 4,
    parameter int unsigned EVAL_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [NUM_BITS-1:0]            s_data,
    input  logic                           s_last,
    input  logic                           s_target,
    output logic [NUM_INPUTS*NUM_BITS-1:0] x_out,
    output logic [NUM_INPUTS*NUM_BITS-1:0] w_out,
    input  logic                           s_neuron,
    output logic                           res_valid,
    output logic                           res_miss,
    output logic [ERR_CNT_W-1:0]           err_cnt,
    input  logic                           clr_cnt
);

    localparam int unsigned IdxW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned EvW  = $clog2(EVAL_CYCLES + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_INPUTS - 1);
    localparam logic [EvW-1:0]  LastEv  = EvW'(EVAL_CYCLES - 1);

    typedef logic [NUM_INPUTS-1:0][NUM_BITS-1:0] bank_t;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [EvW-1:0]       ev_q, ev_d;
    bank_t                x_q, x_d;
    bank_t                w_q, w_d;
    logic                 target_q, target_d;
    logic                 y_q, y_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [NUM_BITS-1:0]  w_upd;

    // Single updater shared across all weights; idx_q selects the pair being trained.
    weight_updater #(
        .NUM_BITS(NUM_BITS)
    ) u_weight_updater (
        .w_i  (w_q[idx_q]),
        .x_i  (x_q[idx_q]),
        .add_i(target_q),
        .w_o  (w_upd)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ev_d      = ev_q;
        x_d       = x_q;
        w_d       = w_q;
        target_d  = target_q;
        y_d       = y_q;
        err_cnt_d = err_cnt_q;
        s_ready   = 1'b0;
        res_valid = 1'b0;
        res_miss  = 1'b0;

        case (state_q)
            StLoad: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    x_d[idx_q] = s_data;
                    idx_d      = idx_q + IdxW'(1);
                    if (s_last || (idx_q == LastIdx)) begin
                        target_d = s_target;
                        idx_d    = '0;
                        ev_d     = '0;
                        state_d  = StEval;
                    end
                end
            end
            StEval: begin
                if (ev_q == LastEv) begin
                    y_d     = s_neuron;
                    state_d = (s_neuron == target_q) ? StResult : StUpdate;
                end else begin
                    ev_d = ev_q + EvW'(1);
                end
            end
            StUpdate: begin
                w_d[idx_q] = w_upd;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StResult;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StResult: begin
                res_valid = 1'b1;
                res_miss  = (y_q != target_q);
                x_d       = '0;
                if (res_miss && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
                state_d = StLoad;
            end
            default: state_d = StLoad;
        endcase

        if (clr_cnt) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StLoad;
            idx_q     <= '0;
            ev_q      <= '0;
            x_q       <= '0;
            w_q       <= '0;
            target_q  <= 1'b0;
            y_q       <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ev_q      <= ev_d;
            x_q       <= x_d;
            w_q       <= w_d;
            target_q  <= target_d;
            y_q       <= y_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign x_out   = x_q;
    assign w_out   = w_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer with a threshold-1 neuron and a sample-level behavioural model.
`timescale 1ns/1ps
module tb_perceptron_trainer;

    localparam int NI = 4;
    localparam int NB = 4;
    localparam int EC = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [NB-1:0]   s_data = '0;
    logic            s_last = 1'b0;
    logic            s_target = 1'b0;
    logic [NI*NB-1:0] x_out;
    logic [NI*NB-1:0] w_out;
    logic            s_neuron;
    logic            res_valid;
    logic            res_miss;
    logic [15:0]     err_cnt;
    logic            clr_cnt = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    int  mw[NI];
    int  model_err;
    bit  chk_en = 1'b0;
    int  bq[$];
    int  last_lat;
    bit  last_miss;

    perceptron_trainer #(
        .NUM_INPUTS (NI),
        .NUM_BITS   (NB),
        .EVAL_CYCLES(EC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_target (s_target),
        .x_out    (x_out),
        .w_out    (w_out),
        .s_neuron (s_neuron),
        .res_valid(res_valid),
        .res_miss (res_miss),
        .err_cnt  (err_cnt),
        .clr_cnt  (clr_cnt)
    );

    always #5 clk = ~clk;

    // Reference neuron: S = (X . W) > 1
    always_comb begin
        int dot;
        int xi;
        int wi;
        dot = 0;
        for (int i = 0; i < NI; i++) begin
            xi  = int'($signed(x_out[i*NB +: NB]));
            wi  = int'($signed(w_out[i*NB +: NB]));
            dot = dot + xi * wi;
        end
        s_neuron = (dot > 1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int fit(input int v);
        int r;
`ifdef PERCEPTRON_TRAINER_SAT_EN
        r = (v > 7) ? 7 : ((v < -8) ? -8 : v);
`else
        r = v & 15;
        if (r > 7) r = r - 16;
`endif
        return r;
    endfunction

    function automatic logic [NI*NB-1:0] model_w_bus();
        logic [NI*NB-1:0] b;
        for (int i = 0; i < NI; i++) b[i*NB +: NB] = NB'(mw[i]);
        return b;
    endfunction

    // Idle-cycle comparison against the model whenever no sample is in flight.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("idle w_out", 32'(w_out), 32'(model_w_bus()));
            chk("idle err_cnt", 32'(err_cnt), model_err);
            chk("idle s_ready", 32'(s_ready), 32'd1);
            chk("idle res_valid", 32'(res_valid), 32'd0);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NI; i++) mw[i] = 0;
        model_err = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic run_sample(input bit tgt, input bit use_last, input bit do_clr,
                              input bit abort_upd);
        int nacc;
        int xs[NI];
        int dot;
        bit miss;
        int lat;
        int exp_lat;
        logic [NI*NB-1:0] xb;

        nacc = (bq.size() < NI) ? bq.size() : NI;
        dot = 0;
        for (int i = 0; i < NI; i++) begin
            xs[i] = (i < nacc) ? bq[i] : 0;
            xb[i*NB +: NB] = NB'(xs[i]);
            dot = dot + xs[i] * mw[i];
        end
        miss = ((dot > 1) != tgt);
        exp_lat = 1 + EC + (miss ? NI : 0);

        chk_en = 1'b0;
        for (int k = 0; k < nacc; k++) begin
            s_valid  = 1'b1;
            s_data   = NB'(bq[k]);
            s_last   = use_last && (k == bq.size() - 1);
            s_target = tgt;
            chk("load s_ready", 32'(s_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        if (bq.size() > nacc) begin
            s_valid = 1'b1;
            s_data  = NB'(bq[nacc]);
            s_last  = 1'b1;
            chk("extra beat s_ready", 32'(s_ready), 32'd0);
        end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
        chk("eval x_out", 32'(x_out), 32'(xb));
        chk("eval res_valid", 32'(res_valid), 32'd0);

        lat = 1;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            lat++;
            if (abort_upd && lat == 4) begin
                chk("partial w before abort", 32'(w_out), 32'h0021);
                rst = 1'b1;
                #1;
                model_reset();
                chk("abort w_out", 32'(w_out), 32'd0);
                chk("abort err_cnt", 32'(err_cnt), 32'd0);
                chk("abort s_ready", 32'(s_ready), 32'd1);
                chk("abort res_valid", 32'(res_valid), 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                for (int c = 0; c < 8; c++) begin
                    chk("no pulse after abort", 32'(res_valid), 32'd0);
                    @(posedge clk);
                    #1;
                end
                chk_en = 1'b1;
                return;
            end
        end
        last_lat = lat;
        if (!res_valid) begin
            chk("res_valid timeout", 32'd0, 32'd1);
            chk_en = 1'b1;
            return;
        end
        chk("latency", lat, exp_lat);
        chk("res_miss", 32'(res_miss), 32'(miss));
        last_miss = res_miss;
        if (miss) begin
            for (int i = 0; i < NI; i++) mw[i] = fit(mw[i] + (tgt ? xs[i] : -xs[i]));
            if (model_err < 65535) model_err++;
        end
        if (do_clr) model_err = 0;
        chk("result w_out", 32'(w_out), 32'(model_w_bus()));
        chk("result s_ready", 32'(s_ready), 32'd0);
        clr_cnt = do_clr;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("single pulse", 32'(res_valid), 32'd0);
        chk("x cleared", 32'(x_out), 32'd0);
        chk("next s_ready", 32'(s_ready), 32'd1);
        chk("err_cnt", 32'(err_cnt), model_err);
        chk_en = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("reset s_ready", 32'(s_ready), 32'd1);
        chk("reset res_valid", 32'(res_valid), 32'd0);
        chk("reset res_miss", 32'(res_miss), 32'd0);
        chk("reset err_cnt", 32'(err_cnt), 32'd0);
        chk("reset w_out", 32'(w_out), 32'd0);
        chk("reset x_out", 32'(x_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        bq = '{1, 2, 3, 4};
        run_sample(1'b1, 1'b1, 1'b0, 1'b0);
        chk("s1 latency lit", last_lat, 6);
        chk("s1 miss lit", 32'(last_miss), 32'd1);
        chk("s1 w lit", 32'(w_out), 32'h4321);
        chk("s1 err lit", 32'(err_cnt), 32'd1);
        idle(2);

        run_sample(1'b1, 1'b1, 1'b0, 1'b0);
        chk("s2 latency lit", last_lat, 2);
        chk("s2 miss lit", 32'(last_miss), 32'd0);
        chk("s2 w lit", 32'(w_out), 32'h4321);
        idle(2);

        bq = '{5, -1};
        run_sample(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Five beats offered, no s_last: sample ends on beat 4, X={1,1,1,1}, dot 10 vs target 0.
        bq = '{1, 1, 1, 1, 9};
        run_sample(1'b0, 1'b0, 1'b0, 1'b0);
        chk("s4 w lit", 32'(w_out), 32'h3210);
        chk("s4 err lit", 32'(err_cnt), 32'd2);
        idle(2);

        do_reset();
        bq = '{7, -8};
        run_sample(1'b1, 1'b1, 1'b0, 1'b0);
        bq = '{3, 4};
        run_sample(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef PERCEPTRON_TRAINER_SAT_EN
        chk("pos overflow lit", 32'(w_out), 32'h00C7);
`else
        chk("pos overflow lit", 32'(w_out), 32'h00CA);
`endif
        idle(2);

        do_reset();
        bq = '{-8, 7};
        run_sample(1'b1, 1'b1, 1'b0, 1'b0);
        bq = '{2, 3};
        run_sample(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PERCEPTRON_TRAINER_SAT_EN
        chk("neg overflow lit", 32'(w_out), 32'h0048);
`else
        chk("neg overflow lit", 32'(w_out), 32'h0046);
`endif
        idle(2);

        do_reset();
        bq = '{1, 2, 3, 4};
        run_sample(1'b1, 1'b1, 1'b0, 1'b1);
        idle(2);

        chk_en = 1'b0;
        model_err = 65534;
        force dut.err_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.err_cnt_q;
        chk("preload err", 32'(err_cnt), 32'h0000FFFE);
        chk_en = 1'b1;
        idle(1);
        bq = '{0};
        run_sample(1'b1, 1'b1, 1'b0, 1'b0);
        chk("err to max lit", 32'(err_cnt), 32'h0000FFFF);
        run_sample(1'b1, 1'b1, 1'b0, 1'b0);
        chk("err sat lit", 32'(err_cnt), 32'h0000FFFF);
        run_sample(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr over miss lit", 32'(err_cnt), 32'd0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1);
    end

endmodule
